input_port: RTL and testbench
=============================

# input_port

Byte-wide input port for the SAP-1 datapath: the receiving counterpart of the output register. It accepts bytes from an external producer over a valid/ready handshake, buffers them in a small FIFO, and places the oldest byte onto the shared W bus when the controller asserts its enable. Occupancy and error status are visible to the controller and to the external side.

## Interface
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in_data  input  8  byte offered by external producer.
- in_valid  input  1  producer has a byte on in_data.
- in_ready  output  1  port can accept a byte this cycle.
- enable  input  1  controller drives this port onto the W bus.
- w_bus  output  8  shared bus; high-impedance when enable is low.
- empty  output  1  FIFO holds no bytes.
- full  output  1  FIFO holds DEPTH bytes.
- count  output  log2(DEPTH)+1  bytes currently held.
- underflow  output  1  sticky; read attempted while empty.
- clr_err  input  1  synchronous clear of underflow.

## Operation
- Storage: DEPTH x 8 array, write pointer, read pointer (log2(DEPTH) bits, wrap modulo DEPTH), count register.
- Push: in_valid && in_ready at rising edge writes in_data at write pointer, advances write pointer.
- in_ready = !full, combinational from count. No push when full; in_data is ignored, not dropped silently into storage.
- Pop: enable && !empty at rising edge advances read pointer.
- Bus drive, combinational:
  - enable low: w_bus = 8'hZZ.
  - enable high, not empty: w_bus = byte at read pointer (show-ahead).
  - enable high, empty: w_bus = 8'h00, no pointer change, underflow set at that edge.
- Simultaneous push and pop, not empty and not full: both occur; count unchanged.
- Push while empty with enable high: push occurs, pop does not; bus shows 8'h00 that cycle, underflow sets; the byte is available next cycle.
- Pop while full with in_valid high: pop occurs, push does not (in_ready was low); in_ready rises next cycle.
- count: +1 push only, -1 pop only, unchanged otherwise; never exceeds DEPTH or goes below 0.
- empty = (count == 0); full = (count == DEPTH).
- underflow: set on enable && empty; cleared by clr_err; set takes priority over clr_err in the same cycle.
- Array contents are not reset; only pointers, count, flags.

## Timing
- Reset values: count 0, empty 1, full 0, in_ready 1, underflow 0, pointers 0; w_bus follows enable (Z when low, 8'h00 when high).
- Reset asserted mid-transfer discards all buffered bytes immediately, without waiting for a clock edge.
- Producer-to-bus latency: a byte pushed at edge N is on w_bus in the cycle after edge N if enable is high.
- Bus output is combinational from enable and the head entry; no clock delay between enable rising and bus data.
- Throughput: one push and one pop per cycle sustained.
- Flags and in_ready update on the same edge as the push or pop that changes count.

## Test plan
- Reset with enable low -> w_bus Z, empty 1, in_ready 1, count 0; with enable high -> w_bus 8'h00.
- Push 8'h0F, 8'hA5, 8'h3C with enable low, then enable 3 cycles -> w_bus 8'h0F, 8'hA5, 8'h3C in order, then empty 1, count 0.
- Push 4 bytes (DEPTH=4) -> full 1, in_ready 0; a 5th byte 8'hFF offered is not stored; pop 4 -> FF never appears on the bus.
- Run 10 bytes with in_valid and enable both held high (after a first push) -> output order equals input order, count stays 1, pointers wrap cleanly.
- Enable while empty -> w_bus 8'h00, underflow 1, held until clr_err pulse -> 0; enable while empty together with clr_err -> underflow stays 1.
- Assert reset with 3 bytes buffered -> count 0, empty 1 without a clock edge; next push/pop sequence behaves as after power-up.

Source files
------------

// File: rtl/input_port.sv
// Byte-wide SAP-1 input port: valid/ready producer side, show-ahead FIFO,
// and a tri-state W-bus driver gated by the controller's enable.
module input_port #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       enable,
  output logic [7:0]                 w_bus,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign pop      = enable && !empty;

  // Show-ahead head byte; 8'h00 while empty so an underflowing read is benign.
  assign w_bus = !enable ? 8'hzz : (empty ? 8'h00 : mem[rd_ptr]);

  // NOTE: the storage array has no reset; only pointers and count define
  // which entries are valid, so clearing the array would just cost logic.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Setting wins over clearing so a same-cycle error is never lost.
      if (enable && empty) underflow <= 1'b1;
      else if (clr_err)    underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_input_port.sv
// Self-checking bench for input_port: directed scenarios plus random traffic
// compared against a queue-based model of the FIFO and the sticky error flag.
module tb_input_port;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          enable;
  logic [7:0]    w_bus;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          underflow;
  logic          clr_err;

  input_port #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .enable    (enable),
    .w_bus     (w_bus),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .underflow (underflow),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  // Reference model: bytes held, in arrival order, plus the sticky flag.
  logic [7:0] q[$];
  bit         uf_m;
  int         n_checks = 0;
  int         n_pass   = 0;

  function automatic logic [7:0] exp_bus();
    return (q.size() == 0) ? 8'h00 : q[0];
  endfunction

  task automatic drive(input bit v, input logic [7:0] d, input bit en, input bit clr);
    in_valid = v;
    in_data  = d;
    enable   = en;
    clr_err  = clr;
    #1;
  endtask

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic tick();
    bit do_pop, do_push, was_empty;
    @(posedge clk);
    was_empty = (q.size() == 0);
    do_pop    = enable && !was_empty;
    do_push   = in_valid && (q.size() < DEPTH);
    if (enable && was_empty) uf_m = 1'b1;
    else if (clr_err)        uf_m = 1'b0;
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back(in_data);
    @(negedge clk);
  endtask

  task automatic model_reset();
    q.delete();
    uf_m = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 8'h00, 0, 0);
    model_reset();
    n_checks++;
    if ({count, empty, full, in_ready, underflow} !== {CW'(0), 1'b1, 1'b0, 1'b1, 1'b0})
      $display("FAIL reset_flags: count=%0d empty=%b full=%b in_ready=%b underflow=%b, want 0 1 0 1 0",
               count, empty, full, in_ready, underflow);
    else n_pass++;
    n_checks++;
    if (!(w_bus === 8'hzz || w_bus === 8'h00))
      $display("FAIL reset_bus_idle: w_bus=%h, want undriven", w_bus);
    else n_pass++;
    drive(0, 8'h00, 1, 0);
    n_checks++;
    if (w_bus !== 8'h00) $display("FAIL reset_bus_enabled: w_bus=%h, want 00", w_bus);
    else n_pass++;
    drive(0, 8'h00, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ordered();
    logic [7:0] bytes [3];
    bytes[0] = 8'h0F; bytes[1] = 8'hA5; bytes[2] = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      drive(1, bytes[i], 0, 0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 8'h00, 1, 0);
      n_checks++;
      if (w_bus !== bytes[i] || w_bus !== exp_bus())
        $display("FAIL ordered_bus[%0d]: w_bus=%h, want %h", i, w_bus, bytes[i]);
      else n_pass++;
      tick();
    end
    drive(0, 8'h00, 0, 0);
    n_checks++;
    if (empty !== 1'b1 || count !== CW'(0))
      $display("FAIL ordered_drained: empty=%b count=%0d, want 1 0", empty, count);
    else n_pass++;
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 8'($urandom_range(1, 254)), 0, 0);
      tick();
    end
    n_checks++;
    if (full !== 1'b1 || in_ready !== 1'b0 || count !== CW'(DEPTH))
      $display("FAIL full_flags: full=%b in_ready=%b count=%0d, want 1 0 %0d",
               full, in_ready, count, DEPTH);
    else n_pass++;
    n_checks++;
    if (!(w_bus === 8'hzz || w_bus === 8'h00))
      $display("FAIL full_bus_idle: w_bus=%h, want undriven", w_bus);
    else n_pass++;
    drive(1, 8'hFF, 0, 0);
    tick();
    drive(0, 8'h00, 0, 0);
    n_checks++;
    if (count !== CW'(DEPTH)) $display("FAIL full_no_push: count=%0d, want %0d", count, DEPTH);
    else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 8'h00, 1, 0);
      n_checks++;
      if (w_bus === 8'hFF || w_bus !== exp_bus())
        $display("FAIL full_pop[%0d]: w_bus=%h, want %h", i, w_bus, exp_bus());
      else n_pass++;
      tick();
    end
    drive(0, 8'h00, 0, 0);
    n_checks++;
    if (empty !== 1'b1) $display("FAIL full_drained: empty=%b, want 1", empty);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    drive(1, 8'($urandom), 0, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1, 8'($urandom), 1, 0);
      if (w_bus !== exp_bus() || count !== CW'(1)) begin
        bad++;
        $display("FAIL b2b[%0d]: w_bus=%h count=%0d, want %h 1", i, w_bus, count, exp_bus());
      end
      tick();
    end
    n_checks++;
    if (bad == 0) n_pass++;
    drive(0, 8'h00, 1, 0);
    n_checks++;
    if (w_bus !== exp_bus()) $display("FAIL b2b_last: w_bus=%h, want %h", w_bus, exp_bus());
    else n_pass++;
    tick();
    drive(0, 8'h00, 0, 0);
  endtask

  task automatic test_underflow();
    drive(0, 8'h00, 1, 0);
    n_checks++;
    if (w_bus !== 8'h00) $display("FAIL uf_bus: w_bus=%h, want 00", w_bus);
    else n_pass++;
    tick();
    drive(0, 8'h00, 0, 0);
    tick();
    tick();
    n_checks++;
    if (underflow !== 1'b1 || uf_m !== 1'b1) $display("FAIL uf_sticky: underflow=%b, want 1", underflow);
    else n_pass++;
    drive(0, 8'h00, 0, 1);
    tick();
    drive(0, 8'h00, 0, 0);
    n_checks++;
    if (underflow !== 1'b0) $display("FAIL uf_clear: underflow=%b, want 0", underflow);
    else n_pass++;
    drive(0, 8'h00, 1, 1);
    tick();
    drive(0, 8'h00, 0, 0);
    n_checks++;
    if (underflow !== 1'b1) $display("FAIL uf_set_priority: underflow=%b, want 1", underflow);
    else n_pass++;
    // Push into an empty FIFO while enabled: bus reads 00 now, byte next cycle.
    drive(1, 8'h5A, 1, 1);
    n_checks++;
    if (w_bus !== 8'h00) $display("FAIL uf_push_empty_bus: w_bus=%h, want 00", w_bus);
    else n_pass++;
    tick();
    drive(0, 8'h00, 1, 1);
    n_checks++;
    if (w_bus !== 8'h5A || count !== CW'(1) || underflow !== 1'b1)
      $display("FAIL uf_push_empty_next: w_bus=%h count=%0d underflow=%b, want 5a 1 1",
               w_bus, count, underflow);
    else n_pass++;
    tick();
    drive(0, 8'h00, 0, 1);
    tick();
    drive(0, 8'h00, 0, 0);
    n_checks++;
    if (underflow !== 1'b0 || empty !== 1'b1)
      $display("FAIL uf_final: underflow=%b empty=%b, want 0 1", underflow, empty);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'($urandom_range(1, 255)), 0, 0);
      tick();
    end
    drive(0, 8'h00, 0, 0);
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (count !== CW'(0) || empty !== 1'b1 || in_ready !== 1'b1)
      $display("FAIL async_reset: count=%0d empty=%b in_ready=%b, want 0 1 1", count, empty, in_ready);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    drive(1, 8'hC3, 0, 0);
    tick();
    drive(1, 8'h81, 1, 0);
    n_checks++;
    if (w_bus !== 8'hC3 || count !== CW'(1))
      $display("FAIL post_reset: w_bus=%h count=%0d, want c3 1", w_bus, count);
    else n_pass++;
    tick();
    drive(0, 8'h00, 1, 0);
    n_checks++;
    if (w_bus !== 8'h81) $display("FAIL post_reset_second: w_bus=%h, want 81", w_bus);
    else n_pass++;
    tick();
    drive(0, 8'h00, 0, 0);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 45),
            ($urandom_range(0, 99) < 10));
      if ((enable && w_bus !== exp_bus()) ||
          count !== CW'(q.size()) || empty !== (q.size() == 0) ||
          full !== (q.size() == DEPTH) || in_ready !== (q.size() != DEPTH) ||
          underflow !== uf_m) begin
        bad++;
        if (bad <= 5)
          $display("FAIL random[%0d]: w_bus=%h count=%0d e=%b f=%b rdy=%b uf=%b, want bus %h count %0d uf %b",
                   i, w_bus, count, empty, full, in_ready, underflow, exp_bus(), q.size(), uf_m);
      end
      tick();
    end
    n_checks++;
    if (bad == 0) n_pass++;
  endtask

  initial begin
    test_reset();
    test_ordered();
    test_full();
    test_back_to_back();
    test_underflow();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
